// File: rtl/move_pkg.sv
// Shared types for the pushbutton move controller: direction codes, FSM states, helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package move_pkg;

  // Move direction as presented on move_dir.
  typedef enum logic [1:0] {
    DIR_U = 2'b00,
    DIR_D = 2'b01,
    DIR_L = 2'b10,
    DIR_R = 2'b11
  } move_dir_t;

  // Move FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    LOCK = 2'b10
  } move_state_t;

  // Bit positions inside the {U,D,L,R} button vector.
  localparam int NUM_BTN = 4;
  localparam int BTN_U   = 3;
  localparam int BTN_D   = 2;
  localparam int BTN_L   = 1;
  localparam int BTN_R   = 0;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  // Number of press events present in one cycle (0..4).
  function automatic logic [2:0] count_events(input logic [NUM_BTN-1:0] ev);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_BTN; i++) begin
      n = n + {2'b00, ev[i]};
    end
    return n;
  endfunction

  // Fixed-priority winner U > D > L > R. Caller guarantees at least one bit set.
  function automatic move_dir_t pick_dir(input logic [NUM_BTN-1:0] ev);
    move_dir_t d;
    if (ev[BTN_U])      d = DIR_U;
    else if (ev[BTN_D]) d = DIR_D;
    else if (ev[BTN_L]) d = DIR_L;
    else                d = DIR_R;
    return d;
  endfunction

  // Saturating add of a small per-cycle drop count onto the 8-bit counter.
  function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [2:0] inc);
    logic [8:0] sum;
    sum = {1'b0, acc} + {6'b000000, inc};
    return sum[8] ? DROP_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-button conditioner: 2-flop synchroniser followed by a stability counter.
// Latency: level follows a clean raw change DB_CYCLES+2 edges after the first sampling edge.
// Backpressure: none; free-running, consumes the raw level every cycle.
//
// Ports:
//   clk   - core clock, rising edge
//   clr   - asynchronous active-high reset
//   btn   - raw asynchronous button level (1 = pressed)
//   level - debounced level, registered
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic level
);

  // Counter compares against the target in 8 bits; DB_CYCLES is limited to 2..255.
  localparam logic [7:0] DB_TARGET = 8'(DB_CYCLES);

  logic       sync_meta;
  logic       sync_out;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;

  assign cnt_inc = cnt + 8'd1;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
      cnt       <= 8'd0;
      level     <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_out  <= sync_meta;
      // Any cycle of agreement restarts the stability window, so a bounce
      // shorter than DB_CYCLES never moves the debounced level.
      if (sync_out == level) begin
        cnt <= 8'd0;
      end else if (cnt_inc == DB_TARGET) begin
        level <= ~level;
        cnt   <= 8'd0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/move_input_ctrl.sv
// Turns four raw pushbuttons into single move commands with a valid/ready handshake.
// Latency: move_valid rises DB_CYCLES+3 edges after the first edge sampling a clean press.
// Backpressure: move held stable until move_ready; presses arriving meanwhile are dropped and counted.
//
// Ports:
//   clk        - core clock, rising edge
//   clr        - asynchronous active-high reset
//   btnU..btnR - raw asynchronous button levels (1 = pressed)
//   move_ready - consumer accepts the pending move this cycle
//   move_valid - a move command is pending (high exactly in PEND)
//   move_dir   - 00=U 01=D 10=L 11=R, stable while move_valid
//   btn_db     - debounced levels {U,D,L,R}
//   drop_cnt   - saturating count of discarded press events
module move_input_ctrl
  import move_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] btn_db,
  output logic [7:0] drop_cnt
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] db_prev;
  logic [NUM_BTN-1:0] press;
  logic [2:0]         press_num;
  logic [2:0]         drop_now;
  move_state_t        state;
  move_dir_t          dir_q;

  assign btn_raw = {btnU, btnD, btnL, btnR};

  // ---------------------------------------------------------------------------
  // Per-button synchroniser + debounce
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_btn_debounce (
      .clk  (clk),
      .clr  (clr),
      .btn  (btn_raw[i]),
      .level(btn_db[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Edge detection and drop accounting
  // ---------------------------------------------------------------------------
  // Only rising debounced edges are events; releases are ignored.
  assign press     = btn_db & ~db_prev;
  assign press_num = count_events(press);

  // In IDLE one event wins and the rest are dropped. In PEND (including the
  // cycle that hands off to LOCK) and in LOCK every event is dropped.
  always_comb begin
    drop_now = 3'd0;
    if (state == IDLE) begin
      if (press_num != 3'd0) begin
        drop_now = press_num - 3'd1;
      end
    end else begin
      drop_now = press_num;
    end
  end

  // ---------------------------------------------------------------------------
  // Move FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      move_valid <= 1'b0;
      dir_q      <= DIR_U;
      drop_cnt   <= 8'd0;
      db_prev    <= '0;
    end else begin
      db_prev  <= btn_db;
      drop_cnt <= sat_add(drop_cnt, drop_now);
      case (state)
        IDLE: begin
          if (|press) begin
            dir_q      <= pick_dir(press);
            state      <= PEND;
            move_valid <= 1'b1;
          end
        end
        PEND: begin
          if (move_ready) begin
            state      <= LOCK;
            move_valid <= 1'b0;
          end
        end
        LOCK: begin
          // Wait for every button to be released before arming again.
          if (btn_db == 4'b0000) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          move_valid <= 1'b0;
        end
      endcase
    end
  end

  assign move_dir = dir_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Self-checking bench for move_input_ctrl: directed scenarios plus randomized button traffic.
// Latency: n/a.
// Backpressure: move_ready driven both directed and randomly.
module tb_move_input_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic       btnU, btnD, btnL, btnR;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [3:0] btn_db;
  logic [7:0] drop_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  move_input_ctrl #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .clr       (clr),
    .btnU      (btnU),
    .btnD      (btnD),
    .btnL      (btnL),
    .btnR      (btnR),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .btn_db    (btn_db),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: raw samples reach the debouncer two edges late; a level
  // flips after DB consecutive disagreeing cycles; a rising debounced level is
  // an event seen by the move logic on the following edge.
  // ---------------------------------------------------------------------------
  bit [3:0] m_hist[$];
  bit [3:0] m_db;
  bit [3:0] m_ev;
  int       m_streak[4];
  bit       m_pend;
  bit       m_lock;
  bit [1:0] m_dir;
  int       m_drop;

  function automatic void m_reset();
    m_hist = '{4'h0, 4'h0};
    m_db   = 4'h0;
    m_ev   = 4'h0;
    for (int b = 0; b < 4; b++) m_streak[b] = 0;
    m_pend = 1'b0;
    m_lock = 1'b0;
    m_dir  = 2'd0;
    m_drop = 0;
  endfunction

  function automatic void m_step();
    bit [3:0] sync;
    bit [3:0] nxt;
    int       n;
    n = $countones(m_ev);
    if (!m_pend && !m_lock) begin
      if (n > 0) begin
        m_pend = 1'b1;
        m_drop += n - 1;
        if (m_ev[3])      m_dir = 2'd0;
        else if (m_ev[2]) m_dir = 2'd1;
        else if (m_ev[1]) m_dir = 2'd2;
        else              m_dir = 2'd3;
      end
    end else if (m_pend) begin
      m_drop += n;
      if (move_ready) begin
        m_pend = 1'b0;
        m_lock = 1'b1;
      end
    end else begin
      m_drop += n;
      if (m_db == 4'h0) m_lock = 1'b0;
    end
    if (m_drop > 255) m_drop = 255;

    sync = m_hist.pop_front();
    m_hist.push_back({btnU, btnD, btnL, btnR});
    nxt = m_db;
    for (int b = 0; b < 4; b++) begin
      if (sync[b] != m_db[b]) begin
        m_streak[b]++;
        if (m_streak[b] == DB) begin
          nxt[b]      = ~m_db[b];
          m_streak[b] = 0;
        end
      end else begin
        m_streak[b] = 0;
      end
    end
    m_ev = nxt & ~m_db;
    m_db = nxt;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) m_reset();
    else     m_step();
  end

  // Advance n cycles, checking every output against the model at each falling edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      chk("valid",  move_valid, m_pend);
      chk("dir",    move_dir,   m_dir);
      chk("btn_db", btn_db,     m_db);
      chk("drop",   drop_cnt,   m_drop);
    end
  endtask

  task automatic set_btn(input logic [3:0] v);
    {btnU, btnD, btnL, btnR} = v;
  endtask

  task automatic do_reset();
    set_btn(4'h0);
    move_ready = 1'b0;
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
  endtask

  int first_k;
  int width;

  initial begin
    clr = 1'b1;
    move_ready = 1'b0;
    set_btn(4'h0);
    tick(3);
    chk("rst_valid", move_valid, 0);
    chk("rst_dir",   move_dir,   0);
    chk("rst_db",    btn_db,     0);
    chk("rst_drop",  drop_cnt,   0);
    clr = 1'b0;

    // Single L press with the consumer always ready.
    move_ready = 1'b1;
    set_btn(4'b0010);
    first_k = 0;
    width   = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (move_valid) begin
        if (first_k == 0) first_k = k;
        width++;
      end
      if (k == 7) chk("l_dir", move_dir, 2);
    end
    chk("l_latency", first_k, 7);
    chk("l_width",   width,   1);
    set_btn(4'b0000);
    tick(7);
    // Back in IDLE: a fresh R press must be accepted.
    set_btn(4'b0001);
    tick(7);
    chk("r_after_lock_valid", move_valid, 1);
    chk("r_after_lock_dir",   move_dir,   3);
    chk("r_after_lock_drop",  drop_cnt,   0);
    set_btn(4'b0000);
    tick(10);

    // R bouncing every cycle never debounces.
    do_reset();
    for (int k = 0; k < 30; k++) begin
      btnR = ~btnR;
      tick();
      chk("bounce_db0",   btn_db[0],  0);
      chk("bounce_valid", move_valid, 0);
    end
    chk("bounce_drop", drop_cnt, 0);

    // U and R simultaneously: U wins, R counted as dropped.
    do_reset();
    set_btn(4'b1001);
    tick(7);
    chk("ur_valid", move_valid, 1);
    chk("ur_dir",   move_dir,   0);
    chk("ur_drop",  drop_cnt,   1);
    move_ready = 1'b1;
    set_btn(4'b0000);
    tick(10);

    // D held pending, L press dropped, then handshake.
    do_reset();
    set_btn(4'b0100);
    tick(8);
    set_btn(4'b0000);
    tick(8);
    set_btn(4'b0010);
    tick(8);
    chk("dl_valid", move_valid, 1);
    chk("dl_dir",   move_dir,   1);
    chk("dl_drop",  drop_cnt,   1);
    move_ready = 1'b1;
    tick();
    move_ready = 1'b0;
    chk("dl_taken", move_valid, 0);
    set_btn(4'b0000);
    tick(8);
    set_btn(4'b1000);
    tick(8);
    chk("dl_rearm", move_valid, 1);

    // Saturation of the drop counter.
    do_reset();
    set_btn(4'b1000);
    tick(8);
    for (int k = 0; k < 300; k++) begin
      btnD = 1'b1;
      tick(7);
      btnD = 1'b0;
      tick(7);
    end
    chk("drop_sat", drop_cnt, 255);

    // Reset while pending with U held: move dropped, then re-pressed after reset.
    do_reset();
    set_btn(4'b1000);
    tick(8);
    chk("clr_pre_valid", move_valid, 1);
    clr = 1'b1;
    #1;
    chk("clr_now_valid", move_valid, 0);
    chk("clr_now_drop",  drop_cnt,   0);
    tick(3);
    clr = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) chk("clr_k6_valid", move_valid, 0);
      if (k == 7) begin
        chk("clr_k7_valid", move_valid, 1);
        chk("clr_k7_dir",   move_dir,   0);
      end
    end

    // Randomized traffic: held patterns of random length (short ones act as
    // bounces), random consumer readiness and occasional resets.
    do_reset();
    for (int seg = 0; seg < 250; seg++) begin
      set_btn(($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
      move_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 49) == 0) clr = 1'b1;
      tick($urandom_range(1, 12));
      clr = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
